// File: rtl/tmds_rx_channel.sv
// Single-channel TMDS receiver: recovers the 10-bit symbol boundary from
// blanking-period control symbols and decodes one symbol per 5 clk_bit
// cycles (2 serial bits per cycle, LSB-first line order).
module tmds_rx_channel #(
   parameter int CTRL_RUN_LOCK = 8,
   parameter int HUNT_TIMEOUT  = 1024,
   parameter int LOSS_TIMEOUT  = 4096
) (
   input  logic       clk_bit,
   input  logic       rst_n_bit,
   input  logic       en,
   input  logic [1:0] sdata,
   output logic       sym_valid,
   output logic       de,
   output logic [7:0] data,
   output logic [1:0] ctrl,
   output logic [9:0] raw_sym,
   output logic       locked
);

   localparam int RUN_W  = $clog2(CTRL_RUN_LOCK + 1);
   localparam int HUNT_W = $clog2(HUNT_TIMEOUT + 1);
   localparam int LOSS_W = $clog2(LOSS_TIMEOUT + 1);

   typedef enum logic {HUNT, LOCKED} state_t;

   // The two oldest bits of the 12-bit line history never fall inside a
   // capture window, so only hist[11:3] is stored.
   logic [11:3]       hist;
   logic              off;
   logic [2:0]        phase;
   logic              skip;
   state_t            state;
   logic [HUNT_W-1:0] hunt_ctr;
   logic [LOSS_W-1:0] loss_ctr;
   logic [RUN_W-1:0]  ctrl_run;

   logic [11:1]       hist_d;
   logic              off_d, skip_d, capture, slip, is_ctrl, run_hit;
   logic [2:0]        phase_d;
   state_t            state_d;
   logic [HUNT_W-1:0] hunt_d, hunt_inc;
   logic [LOSS_W-1:0] loss_d, loss_inc;
   logic [RUN_W-1:0]  run_d, run_inc;
   logic [9:0]        cand, q;
   logic [7:0]        dec;
   logic [1:0]        ctrl_code;
   logic              sym_valid_d, de_d;
   logic [7:0]        data_d;
   logic [1:0]        ctrl_d;
   logic [9:0]        raw_d;

   assign locked = (state == LOCKED);

   // Next-state logic: shift, capture window, classify/decode, alignment FSM.
   // NOTE: every variable written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      hist_d      = {sdata, hist[11:3]};
      cand        = off ? hist_d[10:1] : hist_d[11:2];
      capture     = (phase == 3'd4) && !skip;

      is_ctrl   = 1'b1;
      ctrl_code = 2'b00;
      case (cand)
         10'h354: ctrl_code = 2'b00;
         10'h0AB: ctrl_code = 2'b01;
         10'h154: ctrl_code = 2'b10;
         10'h2AB: ctrl_code = 2'b11;
         default: is_ctrl = 1'b0;
      endcase

      q      = cand[9] ? {cand[9:8], ~cand[7:0]} : cand;
      dec[0] = q[0];
      for (int i = 1; i < 8; i++)
         dec[i] = q[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);

      run_inc  = !is_ctrl ? '0 :
                 (ctrl_run == RUN_W'(CTRL_RUN_LOCK)) ? ctrl_run : ctrl_run + 1'b1;
      run_hit  = (run_inc == RUN_W'(CTRL_RUN_LOCK));
      hunt_inc = hunt_ctr + 1'b1;
      loss_inc = loss_ctr + 1'b1;

      phase_d     = (phase == 3'd4) ? 3'd0 : phase + 3'd1;
      skip_d      = 1'b0;
      off_d       = off;
      slip        = 1'b0;
      state_d     = state;
      hunt_d      = hunt_ctr;
      loss_d      = loss_ctr;
      run_d       = ctrl_run;
      sym_valid_d = 1'b0;
      de_d        = de;
      data_d      = data;
      ctrl_d      = ctrl;
      raw_d       = raw_sym;

      if (capture) begin
         run_d = run_inc;
         if (state == HUNT) begin
            if (run_hit) begin
               state_d = LOCKED;
               hunt_d  = '0;
               loss_d  = '0;
            end else if (hunt_inc == HUNT_W'(HUNT_TIMEOUT)) begin
               slip   = 1'b1;
               hunt_d = '0;
               run_d  = '0;
            end else begin
               hunt_d = hunt_inc;
            end
         end else begin
            if (run_hit) begin
               loss_d = '0;
            end else if (loss_inc == LOSS_W'(LOSS_TIMEOUT)) begin
               state_d = HUNT;
               slip    = 1'b1;
               hunt_d  = '0;
               loss_d  = '0;
               run_d   = '0;
            end else begin
               loss_d = loss_inc;
            end
         end

         // The symbol that completes a lock run is emitted; the one that
         // drops lock is not.
         if (state_d == LOCKED) begin
            sym_valid_d = 1'b1;
            de_d        = !is_ctrl;
            data_d      = is_ctrl ? data : dec;
            ctrl_d      = is_ctrl ? ctrl_code : ctrl;
            raw_d       = cand;
         end

         // off 0->1 moves the window one bit earlier in place; off 1->0
         // stretches the symbol period to 6 cycles by idling one cycle at
         // phase 4 without capturing.
         if (slip) begin
            off_d = ~off;
            if (off) begin
               phase_d = 3'd4;
               skip_d  = 1'b1;
            end
         end
      end
   end

   // State register; en=0 synchronously returns everything to reset values.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values computed above, independent of block order.
   always_ff @(posedge clk_bit or negedge rst_n_bit) begin
      if (!rst_n_bit) begin
         hist      <= '0;
         off       <= 1'b0;
         phase     <= 3'd0;
         skip      <= 1'b0;
         state     <= HUNT;
         hunt_ctr  <= '0;
         loss_ctr  <= '0;
         ctrl_run  <= '0;
         sym_valid <= 1'b0;
         de        <= 1'b0;
         data      <= 8'd0;
         ctrl      <= 2'd0;
         raw_sym   <= 10'd0;
      end else if (!en) begin
         hist      <= '0;
         off       <= 1'b0;
         phase     <= 3'd0;
         skip      <= 1'b0;
         state     <= HUNT;
         hunt_ctr  <= '0;
         loss_ctr  <= '0;
         ctrl_run  <= '0;
         sym_valid <= 1'b0;
         de        <= 1'b0;
         data      <= 8'd0;
         ctrl      <= 2'd0;
         raw_sym   <= 10'd0;
      end else begin
         hist      <= hist_d[11:3];
         off       <= off_d;
         phase     <= phase_d;
         skip      <= skip_d;
         state     <= state_d;
         hunt_ctr  <= hunt_d;
         loss_ctr  <= loss_d;
         ctrl_run  <= run_d;
         sym_valid <= sym_valid_d;
         de        <= de_d;
         data      <= data_d;
         ctrl      <= ctrl_d;
         raw_sym   <= raw_d;
      end
   end

endmodule
